sd_init_seq: RTL and testbench
==============================

SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 1000, the maximum number of ACMD41 attempts before failure.
REQ-002 SHALL have parameter VHS, default 4'b0001, the CMD8 supply-voltage field.
REQ-003 SHALL have parameter CHECK_PATTERN, default 8'hAA, the CMD8 echo pattern.
REQ-004 SHALL have parameter OCR_WINDOW, default 24'hFF8000, the ACMD41 voltage window (bits 23:0).
REQ-005 SHALL have ports: clk in 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have ports: reset in 1, asynchronous, active-high.
REQ-007 SHALL have ports: start in 1, begin or restart initialisation.
REQ-008 SHALL have ports: cmd_valid out 1 / cmd_ready in 1, the command handshake to the command engine.
REQ-009 SHALL have ports: cmd_index out 6 / cmd_arg out 32, the command to send.
REQ-010 SHALL have ports: resp_valid in 1 (1-cycle pulse) / resp_timeout in 1 (1-cycle pulse) / resp_data in 128 (short responses in [31:0]).
REQ-011 SHALL have ports: ocr_en, cid_en, rca_en out 1 each, 1-cycle capture strobes.
REQ-012 SHALL have ports: ocr out 32 / cid out 128 / rca out 16 / ccs out 1, the captured card registers.
REQ-013 SHALL have ports: busy out 1 / done out 1 / error out 1 / err_code out 3, status.

Function
REQ-014 SHALL implement states IDLE, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, DONE, ERR; each command state has ISSUE and WAIT sub-phases.
REQ-015 ISSUE SHALL assert cmd_valid with cmd_index and cmd_arg stable until the cycle in which cmd_valid && cmd_ready; WAIT is entered on the next cycle.
REQ-016 Arguments SHALL be: CMD0 0; CMD8 {20'b0,VHS,CHECK_PATTERN}; CMD55 0; ACMD41 {1'b0,hcs,6'b0,OCR_WINDOW}, index 41; CMD2 0; CMD3 0.
REQ-017 start in IDLE, DONE or ERR SHALL go to CMD0 ISSUE, clear retry count, set hcs=1, and clear done/error/err_code; start SHALL be ignored otherwise.
REQ-018 CMD0 SHALL go to CMD8 ISSUE directly after the handshake, with no WAIT phase.
REQ-019 CMD8 WAIT: resp_valid with resp_data[11:0]=={VHS,CHECK_PATTERN} SHALL go to CMD55; a mismatch SHALL go to ERR with err_code 1; resp_timeout SHALL set hcs=0 (v1 card) and go to CMD55.
REQ-020 CMD55 WAIT: resp_valid SHALL go to ACMD41.
REQ-021 ACMD41 WAIT: resp_valid SHALL latch ocr=resp_data[31:0] and pulse ocr_en; then:
- if resp_data[23:0] & OCR_WINDOW == 0: ERR, err_code 4;
- else if bit31 == 1: ccs=bit30 && hcs, go to CMD2;
- else retry count += 1; if the count reaches MAX_RETRY: ERR, err_code 2; otherwise CMD55.
REQ-022 CMD2 WAIT: resp_valid SHALL latch cid=resp_data, pulse cid_en, and go to CMD3.
REQ-023 CMD3 WAIT: resp_valid SHALL latch rca=resp_data[31:16], pulse rca_en, and go to DONE.
REQ-024 resp_timeout in any WAIT other than CMD8 SHALL go to ERR with err_code 3.
REQ-025 resp_valid and resp_timeout in the same cycle SHALL be treated as timeout.
REQ-026 resp_valid or resp_timeout outside WAIT SHALL be ignored.
REQ-027 The retry counter SHALL be $clog2(MAX_RETRY+1) bits wide and SHALL never wrap.
REQ-028 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-029 done SHALL be 1 while in DONE; error SHALL be 1 while in ERR; err_code SHALL hold its value until the next start.
REQ-030 Strobes SHALL be high for exactly the cycle after the accepting response and 0 otherwise.

Reset
REQ-031 reset SHALL force IDLE immediately, including mid-operation.
REQ-032 All outputs SHALL reset to 0: cmd_valid, strobes, ocr, cid, rca, ccs, busy, done, error, err_code; hcs resets to 1 and the retry count to 0.
REQ-033 Sequencing SHALL resume only on start after reset deasserts.

Verification
REQ-034 v2 card: CMD8 echo 12'h1AA, ACMD41 returns 32'h00FF8000 twice then 32'hC0FF8000, CMD3 returns 32'h12340500 -> commands 0,8,55,41,55,41,55,41,2,3; ccs=1; rca=16'h1234; done=1.
REQ-035 v1 card: CMD8 timeout, ACMD41 returns 32'h80FF8000 -> ACMD41 arg bit30=0; ccs=0; done=1.
REQ-036 CMD8 echo 12'h1AB -> error=1, err_code=1, no CMD55 issued.
REQ-037 MAX_RETRY=3 with ACMD41 always 32'h00FF8000 -> exactly 3 ACMD41 sent; err_code=2.
REQ-038 ACMD41 returns 32'h80000000 -> err_code=4; CMD2 timeout -> err_code=3.
REQ-039 reset in ACMD41 WAIT, with cmd_ready held low during CMD0 ISSUE -> IDLE, all outputs 0; after start, cmd_valid is held and args stay stable until cmd_ready.

Source files
------------

// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card identification sequencer (CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3)
// capturing OCR, CID and RCA, with retry limit and error reporting.
module sd_init_seq #(
  parameter int          MAX_RETRY     = 1000,
  parameter logic [3:0]  VHS           = 4'b0001,
  parameter logic [7:0]  CHECK_PATTERN = 8'hAA,
  parameter logic [23:0] OCR_WINDOW    = 24'hFF8000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  input  logic         resp_valid,
  input  logic         resp_timeout,
  input  logic [127:0] resp_data,
  output logic         ocr_en,
  output logic         cid_en,
  output logic         rca_en,
  output logic [31:0]  ocr,
  output logic [127:0] cid,
  output logic [15:0]  rca,
  output logic         ccs,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [2:0]   err_code
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CMD0   = 4'd1;
  localparam logic [3:0] S_CMD8   = 4'd2;
  localparam logic [3:0] S_CMD55  = 4'd3;
  localparam logic [3:0] S_ACMD41 = 4'd4;
  localparam logic [3:0] S_CMD2   = 4'd5;
  localparam logic [3:0] S_CMD3   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  logic [3:0]    state;
  logic          wait_ph;
  logic          hcs;
  logic [RW-1:0] retry;
  logic [RW-1:0] retry_n;

  assign retry_n   = retry + 1'b1;
  assign busy      = !(state == S_IDLE || state == S_DONE || state == S_ERR);
  assign done      = state == S_DONE;
  assign error     = state == S_ERR;
  assign cmd_valid = busy && !wait_ph;

  always_comb begin
    cmd_index = state == S_CMD8   ? 6'd8  :
                state == S_CMD55  ? 6'd55 :
                state == S_ACMD41 ? 6'd41 :
                state == S_CMD2   ? 6'd2  :
                state == S_CMD3   ? 6'd3  : 6'd0;
    cmd_arg   = state == S_CMD8   ? {20'b0, VHS, CHECK_PATTERN} :
                state == S_ACMD41 ? {1'b0, hcs, 6'b0, OCR_WINDOW} : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_ph  <= 1'b0;
      hcs      <= 1'b1;
      retry    <= '0;
      ocr_en   <= 1'b0;
      cid_en   <= 1'b0;
      rca_en   <= 1'b0;
      ocr      <= '0;
      cid      <= '0;
      rca      <= '0;
      ccs      <= 1'b0;
      err_code <= '0;
    end else begin
      ocr_en <= 1'b0;
      cid_en <= 1'b0;
      rca_en <= 1'b0;
      if (start && !busy) begin
        state    <= S_CMD0;
        wait_ph  <= 1'b0;
        retry    <= '0;
        hcs      <= 1'b1;
        err_code <= '0;
      end else if (cmd_valid) begin
        // CMD0 has no response, so it chains straight into CMD8
        if (cmd_ready) begin
          if (state == S_CMD0) state <= S_CMD8;
          else wait_ph <= 1'b1;
        end
      end else if (wait_ph && resp_timeout) begin
        wait_ph <= 1'b0;
        if (state == S_CMD8) begin
          hcs   <= 1'b0;
          state <= S_CMD55;
        end else begin
          state    <= S_ERR;
          err_code <= 3'd3;
        end
      end else if (wait_ph && resp_valid) begin
        wait_ph <= 1'b0;
        case (state)
          S_CMD8: begin
            if (resp_data[11:0] == {VHS, CHECK_PATTERN}) state <= S_CMD55;
            else begin
              state    <= S_ERR;
              err_code <= 3'd1;
            end
          end
          S_CMD55: state <= S_ACMD41;
          S_ACMD41: begin
            ocr    <= resp_data[31:0];
            ocr_en <= 1'b1;
            if ((resp_data[23:0] & OCR_WINDOW) == 24'd0) begin
              state    <= S_ERR;
              err_code <= 3'd4;
            end else if (resp_data[31]) begin
              ccs   <= resp_data[30] && hcs;
              state <= S_CMD2;
            end else begin
              retry <= retry_n;
              if (retry_n == RETRY_LIMIT) begin
                state    <= S_ERR;
                err_code <= 3'd2;
              end else state <= S_CMD55;
            end
          end
          S_CMD2: begin
            cid    <= resp_data;
            cid_en <= 1'b1;
            state  <= S_CMD3;
          end
          S_CMD3: begin
            rca    <= resp_data[31:16];
            rca_en <= 1'b1;
            state  <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: table-driven command/response vectors plus hand-written reset,
// handshake-stall and retry-limit sequences for sd_init_seq.
module tb_sd_init_seq;
  localparam int N = 0, V = 1, T = 2, VT = 3;
  localparam logic [5:0] B = 6'b100000, D = 6'b010000;
  localparam logic [127:0] CID1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] CID2 = 128'h00112233445566778899AABBCCDDEEFF;

  typedef struct {
    bit           st;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           kind;
    logic [127:0] rdata;
    logic [2:0]   strb;
    logic [5:0]   stat;
  } row_t;

  logic clk = 0, rst1 = 1, rst2 = 1, start = 0, cmd_ready = 0;
  logic resp_valid = 0, resp_timeout = 0, sel = 0;
  logic [127:0] resp_data = '0;

  logic cv1, oe1, ce1, re1, ccs1, busy1, done1, err1;
  logic [5:0] idx1;
  logic [31:0] arg1, ocr1;
  logic [127:0] cid1;
  logic [15:0] rca1;
  logic [2:0] ec1;
  logic cv2, oe2, ce2, re2, ccs2, busy2, done2, err2;
  logic [5:0] idx2;
  logic [31:0] arg2, ocr2;
  logic [127:0] cid2;
  logic [15:0] rca2;
  logic [2:0] ec2;

  logic cv;
  logic [5:0] idx, stat;
  logic [31:0] arg;
  logic [2:0] strb;
  assign cv   = sel ? cv2 : cv1;
  assign idx  = sel ? idx2 : idx1;
  assign arg  = sel ? arg2 : arg1;
  assign strb = sel ? {oe2, ce2, re2} : {oe1, ce1, re1};
  assign stat = sel ? {busy2, done2, err2, ec2} : {busy1, done1, err1, ec1};

  int passed = 0, total = 0;
  row_t rows[$];

  always #5 clk = ~clk;

  sd_init_seq dut (
    .clk(clk), .reset(rst1), .start(start), .cmd_valid(cv1), .cmd_ready(cmd_ready),
    .cmd_index(idx1), .cmd_arg(arg1), .resp_valid(resp_valid), .resp_timeout(resp_timeout),
    .resp_data(resp_data), .ocr_en(oe1), .cid_en(ce1), .rca_en(re1), .ocr(ocr1), .cid(cid1),
    .rca(rca1), .ccs(ccs1), .busy(busy1), .done(done1), .error(err1), .err_code(ec1)
  );

  sd_init_seq #(.MAX_RETRY(3)) dut3 (
    .clk(clk), .reset(rst2), .start(start), .cmd_valid(cv2), .cmd_ready(cmd_ready),
    .cmd_index(idx2), .cmd_arg(arg2), .resp_valid(resp_valid), .resp_timeout(resp_timeout),
    .resp_data(resp_data), .ocr_en(oe2), .cid_en(ce2), .rca_en(re2), .ocr(ocr2), .cid(cid2),
    .rca(rca2), .ccs(ccs2), .busy(busy2), .done(done2), .error(err2), .err_code(ec2)
  );

  function automatic row_t mk(bit st, logic [5:0] i, logic [31:0] a, int k,
                              logic [127:0] rd, logic [2:0] sb, logic [5:0] s);
    row_t r;
    r.st = st; r.idx = i; r.arg = a; r.kind = k; r.rdata = rd; r.strb = sb; r.stat = s;
    return r;
  endfunction

  function automatic logic [5:0] e(logic [2:0] c);
    return {3'b001, c};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_row(input int n, input row_t r);
    int w = 0;
    if (r.st) begin
      start = 1; @(negedge clk); start = 0;
    end
    while (!cv && w < 20) begin @(negedge clk); w++; end
    check($sformatf("row%0d cmd_valid seen", n), w < 20, 1);
    check($sformatf("row%0d cmd_index", n), idx, r.idx);
    check($sformatf("row%0d cmd_arg", n), arg, r.arg);
    cmd_ready = 1; @(negedge clk); cmd_ready = 0;
    if (r.kind != N) begin
      resp_data = r.rdata;
      resp_valid = (r.kind == V || r.kind == VT);
      resp_timeout = (r.kind == T || r.kind == VT);
      @(negedge clk);
      resp_valid = 0; resp_timeout = 0;
    end
    check($sformatf("row%0d strobes", n), strb, r.strb);
    check($sformatf("row%0d status", n), stat, r.stat);
    if (r.strb != 0) begin
      @(negedge clk);
      check($sformatf("row%0d strobes off", n), strb, 0);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(i, rows[i]);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, " cmd_valid"}, cv1, 0);
    check({tag, " strobes"}, {oe1, ce1, re1}, 0);
    check({tag, " ocr"}, ocr1, 0);
    check({tag, " cid"}, cid1, 0);
    check({tag, " rca"}, rca1, 0);
    check({tag, " ccs"}, ccs1, 0);
    check({tag, " status"}, {busy1, done1, err1, ec1}, 0);
  endtask

  task automatic quiet(input string nm);
    int seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cv) seen++;
    end
    check(nm, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // v2 card with two busy ACMD41 replies: rows 0-9
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'h00FF8000, 3'b100, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'h00FF8000, 3'b100, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'hC0FF8000, 3'b100, B));
    rows.push_back(mk(0, 2, 0, V, CID1, 3'b010, B));
    rows.push_back(mk(0, 3, 0, V, 128'h12340500, 3'b001, D));
    // v1 card, CMD8 timeout clears HCS: rows 10-15
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, T, 0, 0, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h00FF8000, V, 128'h80FF8000, 3'b100, B));
    rows.push_back(mk(0, 2, 0, V, CID2, 3'b010, B));
    rows.push_back(mk(0, 3, 0, V, 128'h56780000, 3'b001, D));
    // no voltage-window overlap: rows 16-19
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'h80000000, 3'b100, e(4)));
    // CMD2 timeout: rows 20-24
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'hC0FF8000, 3'b100, B));
    rows.push_back(mk(0, 2, 0, T, 0, 0, e(3)));
    // valid and timeout together count as timeout: rows 25-27
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    rows.push_back(mk(0, 55, 0, VT, 128'h120, 0, e(3)));
    // CMD8 echo mismatch: rows 28-29
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, V, 128'h1AB, 0, e(1)));
    // MAX_RETRY=3 instance, card never ready: rows 30-37
    rows.push_back(mk(1, 0, 0, N, 0, 0, B));
    rows.push_back(mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'h00FF8000, 3'b100, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'h00FF8000, 3'b100, B));
    rows.push_back(mk(0, 55, 0, V, 128'h120, 0, B));
    rows.push_back(mk(0, 41, 32'h40FF8000, V, 128'h00FF8000, 3'b100, e(2)));

    repeat (3) @(negedge clk);
    check_idle_outs("in reset");
    rst1 = 0;
    repeat (3) @(negedge clk);
    check_idle_outs("idle after reset");

    run_rows(0, 9);
    check("v2 ccs", ccs1, 1);
    check("v2 rca", rca1, 16'h1234);
    check("v2 ocr", ocr1, 32'hC0FF8000);
    check("v2 cid", cid1, CID1);
    resp_valid = 1; @(negedge clk); resp_valid = 0;
    check("resp in DONE ignored", {busy1, done1, err1, ec1}, D);

    run_rows(10, 15);
    check("v1 ccs", ccs1, 0);
    check("v1 rca", rca1, 16'h5678);
    check("v1 cid", cid1, CID2);

    run_rows(16, 29);
    quiet("no CMD55 after echo mismatch");
    check("mismatch err_code held", ec1, 1);

    // stalled handshake, start ignored while busy, then async reset in ACMD41 WAIT
    start = 1; @(negedge clk); start = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cmd0 stall%0d valid", i), cv1, 1);
      check($sformatf("cmd0 stall%0d idx", i), idx1, 0);
      check($sformatf("cmd0 stall%0d status", i), {busy1, done1, err1, ec1}, B);
      start = (i == 1);
      @(negedge clk);
    end
    start = 0;
    run_row(100, mk(0, 0, 0, N, 0, 0, B));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cmd8 stall%0d valid", i), cv1, 1);
      check($sformatf("cmd8 stall%0d idx", i), idx1, 8);
      check($sformatf("cmd8 stall%0d arg", i), arg1, 32'h1AA);
      @(negedge clk);
    end
    run_row(101, mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    run_row(102, mk(0, 55, 0, V, 128'h120, 0, B));
    run_row(103, mk(0, 41, 32'h40FF8000, V, 128'hC0FF8000, 3'b100, B));
    run_row(104, mk(0, 2, 0, V, CID1, 3'b010, B));
    run_row(105, mk(0, 3, 0, V, 128'hBEEF0000, 3'b001, D));
    start = 1; @(negedge clk); start = 0;
    run_row(106, mk(0, 0, 0, N, 0, 0, B));
    run_row(107, mk(0, 8, 32'h1AA, V, 128'h1AA, 0, B));
    run_row(108, mk(0, 55, 0, V, 128'h120, 0, B));
    cmd_ready = 1; @(negedge clk); cmd_ready = 0;
    check("acmd41 wait no valid", cv1, 0);
    check("acmd41 wait busy", busy1, 1);
    #2 rst1 = 1;
    #1 check_idle_outs("async reset");
    @(negedge clk);
    rst1 = 0;
    resp_valid = 1; @(negedge clk); resp_valid = 0;
    repeat (4) @(negedge clk);
    check_idle_outs("no resume without start");

    rst1 = 1; sel = 1;
    @(negedge clk);
    rst2 = 0;
    @(negedge clk);
    run_rows(30, 37);
    quiet("no 4th ACMD41");
    check("retry err_code held", stat, e(2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
